countdown_timer: RTL and testbench



---
 rtl/countdown_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 31 +++
 rtl/countdown_timer.sv | 121 ++++++++++++
 tb/tb_countdown_timer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and helpers for countdown_timer
package countdown_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} cd_state_t;

    function automatic logic is_busy(cd_state_t s);
        return s != IDLE;
    endfunction

    function automatic int cnt_width(int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides enabled clk cycles down to one tick every PRESCALE cycles
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_width(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    assign tick = en & ~clr & (r_cnt == LAST);

    // phase counter: cleared on demand, advances only while enabled, wraps on tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable prescaled down-counter with pause/abort, auto-reload and sticky irq
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             irq
);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("countdown_timer: PRESCALE must be >= 1");
    end

    cd_state_t        r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic             r_auto;
    logic             r_expired;
    logic             r_irq;
    logic             w_busy;
    logic             w_accept;
    logic             w_zero_start;
    logic             w_en;
    logic             w_clr;
    logic             w_tick;
    logic             w_expire;
    logic             w_fire;

    assign w_busy       = is_busy(r_state);
    assign w_accept     = start_valid & ~w_busy;
    assign w_zero_start = w_accept & (load_val == '0);
    // PAUSED with pause low counts on the resume edge, so each paused edge costs exactly one cycle
    assign w_en         = w_busy & ~abort & ~pause;
    assign w_clr        = w_accept | (w_busy & abort);
    assign w_expire     = w_tick & (r_count == WIDTH'(1));
    assign w_fire       = w_expire | w_zero_start;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (w_en),
        .clr    (w_clr),
        .tick   (w_tick)
    );

    // state and count registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // next state and count: abort beats pause beats tick
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (!w_busy) begin
            if (w_accept) begin
                w_state_nxt = w_zero_start ? IDLE : RUN;
                w_count_nxt = load_val;
            end
        end else if (abort) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end else if (pause) begin
            w_state_nxt = PAUSED;
        end else begin
            w_state_nxt = (w_expire & ~r_auto) ? IDLE : RUN;
            if (w_tick)
                w_count_nxt = !w_expire ? r_count - 1'b1 : (r_auto ? r_reload : '0);
        end
    end

    // period and reload mode captured on a non-zero start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reload <= '0;
            r_auto   <= 1'b0;
        end else if (w_accept & ~w_zero_start) begin
            r_reload <= load_val;
            r_auto   <= auto_reload;
        end
    end

    // expiry strobe and sticky irq, where a new expiry beats a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_expired <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_expired <= w_fire;
            r_irq     <= w_fire ? 1'b1 : (irq_clr ? 1'b0 : r_irq);
        end
    end

    assign start_ready = ~w_busy;
    assign busy        = w_busy;
    assign count       = r_count;
    assign expired     = r_expired;
    assign irq         = r_irq;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: three prescaler variants driven in lockstep against a remaining-cycles model
module tb_countdown_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] load_val;
    logic         start_valid, auto_reload, pause, abort, irq_clr;

    logic [W-1:0] cnt_o [3];
    logic         rdy_o [3];
    logic         bsy_o [3];
    logic         exp_o [3];
    logic         irq_o [3];

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W), .PRESCALE(4)) u0 (
        .clk(clk), .reset_n(reset_n), .load_val(load_val), .start_valid(start_valid),
        .start_ready(rdy_o[0]), .auto_reload(auto_reload), .pause(pause), .abort(abort),
        .irq_clr(irq_clr), .count(cnt_o[0]), .busy(bsy_o[0]), .expired(exp_o[0]), .irq(irq_o[0]));

    countdown_timer #(.WIDTH(W), .PRESCALE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .load_val(load_val), .start_valid(start_valid),
        .start_ready(rdy_o[1]), .auto_reload(auto_reload), .pause(pause), .abort(abort),
        .irq_clr(irq_clr), .count(cnt_o[1]), .busy(bsy_o[1]), .expired(exp_o[1]), .irq(irq_o[1]));

    countdown_timer #(.WIDTH(W), .PRESCALE(2)) u2 (
        .clk(clk), .reset_n(reset_n), .load_val(load_val), .start_valid(start_valid),
        .start_ready(rdy_o[2]), .auto_reload(auto_reload), .pause(pause), .abort(abort),
        .irq_clr(irq_clr), .count(cnt_o[2]), .busy(bsy_o[2]), .expired(exp_o[2]), .irq(irq_o[2]));

    function automatic int ps(int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 2);
    endfunction

    // Model: a running timer is just "active edges left until expiry";
    // the visible count is that figure rounded up to whole prescale periods.
    bit m_busy [3] = '{0, 0, 0};
    bit m_auto [3] = '{0, 0, 0};
    bit m_exp  [3] = '{0, 0, 0};
    bit m_irq  [3] = '{0, 0, 0};
    int m_left [3] = '{0, 0, 0};
    int m_rel  [3] = '{0, 0, 0};

    function automatic int m_count(int i);
        return m_busy[i] ? (m_left[i] + ps(i) - 1) / ps(i) : 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        bit b, e, a;
        int l, r;
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                m_busy[i] <= 0; m_auto[i] <= 0; m_exp[i] <= 0;
                m_irq[i]  <= 0; m_left[i] <= 0; m_rel[i] <= 0;
            end else begin
                b = m_busy[i]; a = m_auto[i]; l = m_left[i]; r = m_rel[i]; e = 0;
                if (!b) begin
                    if (start_valid) begin
                        if (load_val != 0) begin
                            b = 1; r = int'(load_val); l = r * ps(i); a = auto_reload;
                        end else begin
                            e = 1;
                        end
                    end
                end else if (abort) begin
                    b = 0; l = 0;
                end else if (!pause) begin
                    l = l - 1;
                    if (l == 0) begin
                        e = 1;
                        if (a) l = r * ps(i);
                        else b = 0;
                    end
                end
                m_busy[i] <= b; m_auto[i] <= a; m_left[i] <= l; m_rel[i] <= r; m_exp[i] <= e;
                m_irq[i]  <= e ? 1'b1 : (irq_clr ? 1'b0 : m_irq[i]);
            end
        end
    end

    task automatic chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // cycle-by-cycle comparison of every output against the model
    always @(posedge clk) begin
        #1;
        if (cmp_en)
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.count", i), int'(cnt_o[i]), m_count(i));
                chk($sformatf("u%0d.busy", i), int'(bsy_o[i]), int'(m_busy[i]));
                chk($sformatf("u%0d.start_ready", i), int'(rdy_o[i]), int'(!m_busy[i]));
                chk($sformatf("u%0d.expired", i), int'(exp_o[i]), int'(m_exp[i]));
                chk($sformatf("u%0d.irq", i), int'(irq_o[i]), int'(m_irq[i]));
            end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s u%0d.count", tag, i), int'(cnt_o[i]), 0);
            chk($sformatf("%s u%0d.busy", tag, i), int'(bsy_o[i]), 0);
            chk($sformatf("%s u%0d.start_ready", tag, i), int'(rdy_o[i]), 1);
            chk($sformatf("%s u%0d.expired", tag, i), int'(exp_o[i]), 0);
        end
    endtask

    int first [3];
    int pulses [3];

    initial begin
        reset_n = 0; load_val = 0; start_valid = 0; auto_reload = 0;
        pause = 0; abort = 0; irq_clr = 0;
        repeat (2) step();
        chk_idle("reset");
        for (int i = 0; i < 3; i++) chk($sformatf("reset u%0d.irq", i), int'(irq_o[i]), 0);
        reset_n = 1;
        cmp_en  = 1;
        step();

        // one-shot N=3: expiry lands N*P edges after the start edge
        start_valid = 1; load_val = 3; auto_reload = 0;
        step();
        start_valid = 0;
        chk("t1 u0.count after start", int'(cnt_o[0]), 3);
        first = '{-1, -1, -1};
        for (int k = 1; k <= 20; k++) begin
            step();
            for (int i = 0; i < 3; i++) if (exp_o[i] && first[i] < 0) first[i] = k;
            if (k == 4)  chk("t1 u0.count k4", int'(cnt_o[0]), 2);
            if (k == 8)  chk("t1 u0.count k8", int'(cnt_o[0]), 1);
            if (k == 11) chk("t1 u0.busy k11", int'(bsy_o[0]), 1);
            if (k == 12) begin
                chk("t1 u0.count k12", int'(cnt_o[0]), 0);
                chk("t1 u0.busy k12", int'(bsy_o[0]), 0);
                chk("t1 u0.start_ready k12", int'(rdy_o[0]), 1);
            end
        end
        chk("t1 u0 expiry cycle", first[0], 12);
        chk("t1 u1 expiry cycle", first[1], 3);
        chk("t1 u2 expiry cycle", first[2], 6);

        // auto-reload N=2, then abort stops everything
        start_valid = 1; load_val = 2; auto_reload = 1;
        step();
        start_valid = 0;
        pulses = '{0, 0, 0};
        for (int k = 1; k <= 10; k++) begin
            step();
            for (int i = 0; i < 3; i++) pulses[i] += int'(exp_o[i]);
            if (k == 1) chk("t2 u1.count k1", int'(cnt_o[1]), 1);
            if (k == 2) chk("t2 u1.count k2", int'(cnt_o[1]), 2);
        end
        chk("t2 u0 pulses", pulses[0], 1);
        chk("t2 u1 pulses", pulses[1], 5);
        chk("t2 u2 pulses", pulses[2], 2);
        chk("t2 u1.busy", int'(bsy_o[1]), 1);
        abort = 1;
        step();
        abort = 0;
        chk_idle("t2 abort");
        pulses = '{0, 0, 0};
        for (int k = 1; k <= 10; k++) begin
            step();
            for (int i = 0; i < 3; i++) pulses[i] += int'(exp_o[i]);
        end
        for (int i = 0; i < 3; i++) chk($sformatf("t2 u%0d pulses after abort", i), pulses[i], 0);

        // N=5 with pause sampled on 7 edges: each paused edge defers expiry by one cycle
        start_valid = 1; load_val = 5; auto_reload = 0;
        step();
        start_valid = 0;
        first = '{-1, -1, -1};
        for (int k = 1; k <= 40; k++) begin
            step();
            for (int i = 0; i < 3; i++) if (exp_o[i] && first[i] < 0) first[i] = k;
            pause = (k >= 3 && k < 10);
        end
        pause = 0;
        chk("t3 u0 paused expiry", first[0], 27);
        chk("t3 u1 paused expiry", first[1], 12);
        chk("t3 u2 paused expiry", first[2], 17);

        // zero load expires at once; a new expiry wins over irq_clr
        irq_clr = 1;
        step();
        irq_clr = 0;
        for (int i = 0; i < 3; i++) chk($sformatf("t4 u%0d.irq cleared", i), int'(irq_o[i]), 0);
        start_valid = 1; load_val = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4 u%0d.expired zero", i), int'(exp_o[i]), 1);
            chk($sformatf("t4 u%0d.irq zero", i), int'(irq_o[i]), 1);
            chk($sformatf("t4 u%0d.busy zero", i), int'(bsy_o[i]), 0);
        end
        irq_clr = 1;
        step();
        chk("t4 u0.irq set beats clr", int'(irq_o[0]), 1);
        chk("t4 u0.expired again", int'(exp_o[0]), 1);
        start_valid = 0; irq_clr = 0;
        step();
        chk("t4 u0.expired drops", int'(exp_o[0]), 0);
        chk("t4 u0.irq sticky", int'(irq_o[0]), 1);
        irq_clr = 1;
        step();
        irq_clr = 0;
        chk("t4 u0.irq clr", int'(irq_o[0]), 0);

        // start held while busy is ignored; abort on the expiry edge suppresses it
        start_valid = 1; load_val = 2; auto_reload = 0;
        step();
        load_val = 7;
        step();
        chk("t5 u1.count ignores restart", int'(cnt_o[1]), 1);
        chk("t5 u0.count ignores restart", int'(cnt_o[0]), 2);
        start_valid = 0; abort = 1;
        step();
        abort = 0;
        chk_idle("t5 abort at expiry");
        for (int i = 0; i < 3; i++) chk($sformatf("t5 u%0d.irq", i), int'(irq_o[i]), 0);
        repeat (3) step();
        chk("t5 u1.irq later", int'(irq_o[1]), 0);

        // asynchronous reset mid-run
        start_valid = 1; load_val = 3; auto_reload = 1;
        step();
        start_valid = 0;
        repeat (3) step();
        chk("t6 u1.irq before reset", int'(irq_o[1]), 1);
        chk("t6 u0.busy before reset", int'(bsy_o[0]), 1);
        #2 reset_n = 0;
        #1;
        chk_idle("t6 async reset");
        for (int i = 0; i < 3; i++) chk($sformatf("t6 u%0d.irq reset", i), int'(irq_o[i]), 0);
        repeat (2) step();
        reset_n = 1;
        repeat (5) step();
        chk_idle("t6 after release");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
